// File: rtl/mod_updown_counter_if.sv
// Control and status bundle for mod_updown_counter.
// The master drives the counter's controls; the slave is the counter itself.
interface mod_updown_counter_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic             load;
   logic [WIDTH-1:0] d;
   logic [1:0]       mode;
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             dir_up;

   modport master (
      output en, load, d, mode,
      input  q, tc, dir_up
   );

   modport slave (
      input  en, load, d, mode,
      output q, tc, dir_up
   );
endinterface

// File: rtl/mod_updown_counter.sv
// Loadable modulo-N up/down counter with rotate-left mode and a registered wrap pulse.
// All outputs are registered, so no input reaches an output within the same cycle.
module mod_updown_counter #(
   parameter int WIDTH     = 4,
   parameter int MODULUS   = 16,
   parameter int RESET_VAL = 0
) (
   input logic                  clk,
   input logic                  rst_n,
   mod_updown_counter_if.slave  bus
);

   generate
      if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
         $error("mod_updown_counter: WIDTH must be in 2..16");
      end
      if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
         $error("mod_updown_counter: MODULUS must be in 2..2**WIDTH");
      end
      if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset_val
         $error("mod_updown_counter: RESET_VAL must be below MODULUS");
      end
   endgenerate

   // One extra bit lets MODULUS == 2**WIDTH be represented, making every compare against it true.
   localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH + 1)'(MODULUS);
   localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(RESET_VAL);

   typedef enum logic [1:0] {
      MODE_HOLD   = 2'b00,
      MODE_UP     = 2'b01,
      MODE_DOWN   = 2'b10,
      MODE_ROTATE = 2'b11
   } mode_e;

   mode_e            op_mode;
   logic [WIDTH-1:0] rot;
   logic [WIDTH-1:0] q_next;
   logic             tc_next;
   logic             dir_next;

   assign op_mode = mode_e'(bus.mode);
   assign rot     = {bus.q[WIDTH-2:0], bus.q[WIDTH-1]};

   // Wrap checks come before the +1/-1 so the arithmetic never leaves WIDTH bits.
   always_comb begin
      q_next   = bus.q;
      tc_next  = 1'b0;
      dir_next = bus.dir_up;
      if (bus.load) begin
         q_next = ({1'b0, bus.d} < MOD_EXT) ? bus.d : MAX_VAL;
      end else if (bus.en) begin
         case (op_mode)
            MODE_UP: begin
               dir_next = 1'b1;
               if (bus.q == MAX_VAL) begin
                  q_next  = '0;
                  tc_next = 1'b1;
               end else begin
                  q_next = bus.q + WIDTH'(1);
               end
            end
            MODE_DOWN: begin
               dir_next = 1'b0;
               if (bus.q == '0) begin
                  q_next  = MAX_VAL;
                  tc_next = 1'b1;
               end else begin
                  q_next = bus.q - WIDTH'(1);
               end
            end
            MODE_ROTATE: begin
               q_next = ({1'b0, rot} < MOD_EXT) ? rot : '0;
            end
            default: begin
               q_next = bus.q;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.q      <= INIT_VAL;
         bus.tc     <= 1'b0;
         bus.dir_up <= 1'b1;
      end else begin
         bus.q      <= q_next;
         bus.tc     <= tc_next;
         bus.dir_up <= dir_next;
      end
   end

endmodule

// File: doc/mod_updown_counter.md
# mod_updown_counter

Parametrised, loadable, modulo-N up/down counter with a rotate mode and a registered wrap flag. It is the next-generation replacement for the fixed 4-bit loadable counter. Its `q` output feeds the board's binary-to-BCD/seven-segment path, and its `tc` output can cascade into a further counter stage for multi-digit counting.

## Interface
Parameters:
- `WIDTH`, 4: counter width in bits; legal range 2..16.
- `MODULUS`, 16: count modulus N; legal range 2..2^WIDTH; `q` always stays in 0..N-1.
- `RESET_VAL`, 0: value of `q` after reset; must be less than `MODULUS`.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  count enable; gates the mode operations only, not `load`.
- `load`  in  1  synchronous parallel load, active-high.
- `d`  in  WIDTH  parallel load data.
- `mode`  in  2  operation select: 00 hold, 01 up, 10 down, 11 rotate-left.
- `q`  out  WIDTH  counter value, registered.
- `tc`  out  1  terminal-count pulse, registered.
- `dir_up`  out  1  last counting direction, registered; 1 = up.

## Operation
- Reset (`rst_n`=0, asynchronous): `q`=RESET_VAL, `tc`=0, `dir_up`=1. These values hold while reset is asserted.
- Per-edge priority: `load` > (`en` with `mode`) > hold.
- Load:
  - If `d` < MODULUS, `q` takes `d`.
  - Otherwise `q` takes MODULUS-1 (clamp).
  - `tc`=0; `dir_up` is unchanged.
  - `load` wins even when `en`=0.
- Up (`en`=1, `mode`=01):
  - If `q`=MODULUS-1, `q` wraps to 0 and `tc`=1; otherwise `q`+1 and `tc`=0.
  - `dir_up`=1.
- Down (`en`=1, `mode`=10):
  - If `q`=0, `q` wraps to MODULUS-1 and `tc`=1; otherwise `q`-1 and `tc`=0.
  - `dir_up`=0.
- Rotate-left (`en`=1, `mode`=11):
  - r = {`q`[WIDTH-2:0], `q`[WIDTH-1]}.
  - If r < MODULUS, `q`=r; otherwise `q`=0.
  - `tc`=0; `dir_up` is unchanged.
- Hold (`mode`=00, or `en`=0 without `load`): `q` and `dir_up` are unchanged; `tc`=0.
- Arithmetic:
  - All comparisons are unsigned at WIDTH bits.
  - The +1/-1 must not overflow WIDTH: the wrap check precedes the increment.
  - When MODULUS=2^WIDTH, up/down reduce to natural binary wrap.

## Timing
- Latency: every input is sampled on the rising `clk` edge, and `q`, `tc` and `dir_up` reflect it after that same edge, i.e. one cycle.
- No combinational path exists from any input to any output.
- `tc`:
  - High for exactly one cycle: the cycle following the edge that performed a wrap.
  - Continuous wrapping (e.g. MODULUS=2, counting up) gives `tc`=1 on every wrap edge and 0 on the others.
  - Cascading: the next stage's `en` = this stage's `tc` advances the next stage once per wrap, one cycle after the wrap.
- Simultaneous `load`=1 and `en`=1: the load is applied, the count is ignored and `tc`=0.
- Direction change mid-sequence: takes effect on the next edge with no dead cycle, e.g. `q`=0, `mode` switches up to down → `q`=MODULUS-1 with `tc`=1.
- Reset asserted mid-count: outputs return to reset values immediately, without waiting for `clk`.
- Reset deassertion: counting resumes on the first rising edge after `rst_n` goes high. `rst_n` is synchronised externally.
- Parameters outside their legal ranges are rejected at elaboration.

## Test plan
- Reset mid-count: WIDTH=4, MODULUS=10, RESET_VAL=3.
  - Assert `rst_n`=0 between clock edges → `q`=3, `tc`=0, `dir_up`=1 immediately.
  - Release and count up 7 edges → `q` sequence is 4,5,6,7,8,9,0.
  - `tc`=1 only in the cycle with `q`=0.
- Down wrap:
  - `load` `d`=1, then `mode`=10 with `en`=1 for 3 edges → `q` = 0, 9, 8.
  - `tc`=1 only while `q`=9; `dir_up`=0.
- Load clamp and priority:
  - `d`=13 with `load`=1 → `q`=9.
  - `d`=5 with `load`=1, `en`=1, `mode`=01 → `q`=5 (not 6), `tc`=0.
  - `load`=1 with `en`=0, `d`=2 → `q`=2.
- Rotate mode:
  - MODULUS=16, `q`=4'b1001, `mode`=11 → `q`=4'b0011, then 4'b0110.
  - MODULUS=10, `q`=4'b0100 → r=8 gives `q`=8; next r=1 gives `q`=1.
  - MODULUS=10, `q`=4'b0101 → r=10 is not < 10, so `q`=0.
- Hold and enable:
  - `en`=0 for 5 edges at `q`=7 → `q` stays 7, `tc` stays 0.
  - `mode`=00 with `en`=1 → `q` unchanged.
- Cascade: two instances at MODULUS=10, stage 2 `en` = stage 1 `tc`, stage 1 counting up from 0.
  - After 100 edges, plus the one-cycle cascade latency, both stages read 0.
  - Stage 2 steps 0→9 in order with exactly one step per stage-1 wrap.
  - Stage 2 `tc` pulses once.
